// File: rtl/vdma_rd_scheduler_pkg.sv
// Shared types and helpers for the VDMA read-side scheduler.
// Holds the FSM state enum, default widths and the burst-length clamp.
package vdma_rd_scheduler_pkg;

    localparam int DEF_LEN_W = 9;
    localparam int DEF_LVL_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ISSUE,
        DRAIN
    } state_t;

    function automatic logic [15:0] min_len(
        input logic [15:0] rem,
        input int unsigned cap
    );
        if (32'(rem) > cap) return 16'(cap);
        return rem;
    endfunction

endpackage

// File: rtl/vdma_rd_addr_gen.sv
// Per-line burst address generator for the VDMA read scheduler.
// Ports: start/base latch a frame, load captures cmd_addr/cmd_len, adv steps on handshake.
module vdma_rd_addr_gen
    import vdma_rd_scheduler_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int BURST_LEN = 256
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [15:0]       hactive,
    input  logic              load,
    input  logic              adv,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [LEN_W-1:0]  len,
    output logic [15:0]       line_cnt,
    output logic              line_done
);

    logic [ADDR_W-1:0] line_addr;
    logic [15:0]       beat_off;

    assign len = LEN_W'(min_len(hactive - beat_off, BURST_LEN));

    // The accepted burst (cmd_len) decides whether this handshake ends the line.
    assign line_done = (beat_off + 16'(cmd_len)) == hactive;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            line_addr <= '0;
            beat_off  <= '0;
            line_cnt  <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
        end else begin
            if (start) begin
                line_addr <= base;
                beat_off  <= '0;
                line_cnt  <= '0;
            end else if (adv) begin
                if (line_done) begin
                    beat_off  <= '0;
                    line_cnt  <= line_cnt + 16'd1;
                    line_addr <= line_addr + line_stride;
                end else begin
                    beat_off <= beat_off + 16'(cmd_len);
                end
            end
            if (load) begin
                cmd_addr <= line_addr + ADDR_W'(beat_off);
                cmd_len  <= len;
            end
        end
    end

endmodule

// File: rtl/vdma_rd_scheduler.sv
// VDMA read scheduler: splits frames into line bursts, throttled by FIFO space and prefetch window.
// Ports: frame timing (falign/lalign), FIFO status, read command handshake, status outputs.
// Optional: define VDMA_RD_SCHEDULER_STAT_EN to enable the underrun_cnt statistic.
module vdma_rd_scheduler
    import vdma_rd_scheduler_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int BURST_LEN      = 256,
    parameter int FIFO_DEPTH     = 2048,
    parameter int LVL_W          = DEF_LVL_W,
    parameter int PREFETCH_LINES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [15:0]       vactive,
    input  logic [15:0]       hactive,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic              falign,
    input  logic              lalign,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              rd_beat,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              fifo_flush,
    output logic              busy,
    output logic              late_frame,
    output logic [15:0]       underrun_cnt
);

    localparam int SW = LVL_W + 2;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pend_base, start_base;
    logic              abort;
    logic [15:0]       lines_req, lines_used, line_cnt;
    logic [LVL_W-1:0]  outstanding;
    logic [LEN_W-1:0]  len;
    logic [SW-1:0]     need;
    logic              hs, line_done, frame_end, dims_ok;
    logic              space_ok, win_ok, start, load, dec;

    assign hs        = cmd_valid & cmd_ready;
    assign dims_ok   = (vactive != 16'd0) && (hactive != 16'd0);
    assign frame_end = hs && line_done && ((line_cnt + 16'd1) == vactive);
    assign need      = SW'(fifo_level) + SW'(outstanding) + SW'(len);
    assign space_ok  = need <= SW'(FIFO_DEPTH);
    assign win_ok    = (lines_req - lines_used) < 16'(PREFETCH_LINES);
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign dec       = rd_beat && ((outstanding != '0) || hs);

    vdma_rd_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .BURST_LEN (BURST_LEN)
    ) u_addr (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .base        (start_base),
        .line_stride (line_stride),
        .hactive     (hactive),
        .load        (load),
        .adv         (hs),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .len         (len),
        .line_cnt    (line_cnt),
        .line_done   (line_done)
    );

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        start_base = frame_base;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nx = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!enable) begin
                    state_nx = DRAIN;
                end else if (falign && dims_ok) begin
                    start    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (falign) begin
                    state_nx = DRAIN;
                end else if (frame_end) begin
                    state_nx = enable ? WAIT_FRAME : DRAIN;
                end else if (!enable) begin
                    if (!cmd_valid || hs) state_nx = DRAIN;
                end else if (!cmd_valid && space_ok && win_ok) begin
                    load = 1'b1;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    if (abort && enable) begin
                        // Mid-frame restart reuses the frame-start latch path.
                        start_base = pend_base;
                        start      = dims_ok;
                        state_nx   = dims_ok ? ISSUE : WAIT_FRAME;
                    end else begin
                        state_nx = enable ? WAIT_FRAME : IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_valid   <= 1'b0;
            fifo_flush  <= 1'b0;
            late_frame  <= 1'b0;
            abort       <= 1'b0;
            pend_base   <= '0;
            lines_req   <= '0;
            lines_used  <= '0;
            outstanding <= '0;
        end else begin
            state      <= state_nx;
            fifo_flush <= start;
            if (load) cmd_valid <= 1'b1;
            else if (hs || falign) cmd_valid <= 1'b0;
            if (state == ISSUE && falign) late_frame <= 1'b1;
            else if (state == WAIT_FRAME && start) late_frame <= 1'b0;
            if (start) begin
                abort <= 1'b0;
            end else if (falign && (state == ISSUE || state == DRAIN)) begin
                abort     <= 1'b1;
                pend_base <= frame_base;
            end else if (state_nx == IDLE) begin
                abort <= 1'b0;
            end
            if (start) begin
                lines_req  <= '0;
                lines_used <= '0;
            end else begin
                if (hs && line_done) lines_req <= lines_req + 16'd1;
                if (lalign && lines_used < lines_req) lines_used <= lines_used + 16'd1;
            end
            outstanding <= outstanding + (hs ? LVL_W'(cmd_len) : '0) - LVL_W'(dec);
        end
    end

`ifdef VDMA_RD_SCHEDULER_STAT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (falign) begin
            underrun_cnt <= '0;
        end else if (state == ISSUE && fifo_level == '0 &&
                     lines_used < line_cnt && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vdma_rd_scheduler.sv
// Self-checking bench for vdma_rd_scheduler.
// Scoreboard of expected commands, popped on each observed handshake.
module tb_vdma_rd_scheduler;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  len;
    } cmd_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] vactive = '0;
    logic [15:0] hactive = '0;
    logic [31:0] frame_base = '0;
    logic [31:0] line_stride = '0;
    logic        falign = 1'b0;
    logic        lalign = 1'b0;
    logic [11:0] fifo_level = '0;
    logic        rd_beat = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        fifo_flush, busy, late_frame;
    logic [15:0] underrun_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cmds = 0;
    cmd_t sb[$];

    vdma_rd_scheduler dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .enable       (enable),
        .vactive      (vactive),
        .hactive      (hactive),
        .frame_base   (frame_base),
        .line_stride  (line_stride),
        .falign       (falign),
        .lalign       (lalign),
        .fifo_level   (fifo_level),
        .rd_beat      (rd_beat),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .fifo_flush   (fifo_flush),
        .busy         (busy),
        .late_frame   (late_frame),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            n_cmds++;
            if (sb.size() == 0) begin
                check("unexpected_cmd", {32'd0, cmd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                cmd_t e;
                e = sb.pop_front();
                check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                check("cmd_len", 64'(cmd_len), 64'(e.len));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        falign = 1'b0;
        lalign = 1'b0;
        rd_beat = 1'b0;
        cmd_ready = 1'b0;
        fifo_level = '0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic pulse_falign(input logic [31:0] b);
        frame_base = b;
        falign = 1'b1;
        tick();
        falign = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [8:0] l);
        cmd_t c;
        c.addr = a;
        c.len = l;
        sb.push_back(c);
    endtask

    task automatic wait_cmds(input int target, input string tag);
        for (int i = 0; i < 300 && n_cmds < target; i++) tick();
        check(tag, 64'(n_cmds), 64'(target));
    endtask

    initial begin
        int          base0;
        logic        quiet;
        logic [31:0] b1, b2, b3, st;

        #3;
        check("reset_outs",
              {cmd_valid, cmd_addr, cmd_len, fifo_flush, busy, late_frame},
              '0);
        check("reset_underrun", 64'(underrun_cnt), 64'd0);

        // Multi-burst lines: 600 beats -> 256, 256, 88.
        do_reset();
        vactive = 16'd2;
        hactive = 16'd600;
        line_stride = 32'd1000;
        cmd_ready = 1'b1;
        for (int l = 0; l < 2; l++) begin
            push(32'h1000 + 32'(l) * 32'd1000, 9'd256);
            push(32'h1000 + 32'(l) * 32'd1000 + 32'd256, 9'd256);
            push(32'h1000 + 32'(l) * 32'd1000 + 32'd512, 9'd88);
        end
        base0 = n_cmds;
        pulse_falign(32'h1000);
        check("flush_pulse", 64'(fifo_flush), 64'd1);
        check("valid_not_yet", 64'(cmd_valid), 64'd0);
        tick();
        check("falign_latency", 64'(cmd_valid), 64'd1);
        check("flush_one_cycle", 64'(fifo_flush), 64'd0);
        wait_cmds(base0 + 6, "frame_cmds");
        tick();
        check("frame_done_idle", {busy, late_frame}, 64'd0);
        check("sb_empty_1", 64'(sb.size()), 64'd0);

        // FIFO space throttling.
        do_reset();
        vactive = 16'd1;
        hactive = 16'd256;
        fifo_level = 12'd1900;
        cmd_ready = 1'b1;
        pulse_falign(32'h4000);
        repeat (5) tick();
        check("space_stall_1900", 64'(cmd_valid), 64'd0);
        fifo_level = 12'd1793;
        repeat (3) tick();
        check("space_stall_1793", 64'(cmd_valid), 64'd0);
        push(32'h4000, 9'd256);
        base0 = n_cmds;
        fifo_level = 12'd1792;
        tick();
        check("space_go_1792", 64'(cmd_valid), 64'd1);
        wait_cmds(base0 + 1, "space_cmd");

        // Prefetch window.
        do_reset();
        vactive = 16'd4;
        hactive = 16'd100;
        line_stride = 32'h200;
        cmd_ready = 1'b1;
        for (int l = 0; l < 3; l++) push(32'h8000 + 32'(l) * 32'h200, 9'd100);
        base0 = n_cmds;
        pulse_falign(32'h8000);
        repeat (30) tick();
        check("window_two_lines", 64'(n_cmds - base0), 64'd2);
        check("window_stall", 64'(cmd_valid), 64'd0);
        lalign = 1'b1;
        tick();
        lalign = 1'b0;
        repeat (30) tick();
        check("window_third_line", 64'(n_cmds - base0), 64'd3);

        // Backpressure hold.
        do_reset();
        vactive = 16'd1;
        hactive = 16'd50;
        pulse_falign(32'hA000);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_stable", {cmd_valid, cmd_addr, cmd_len},
                  {1'b1, 32'hA000, 9'd50});
            tick();
        end
        // Asynchronous reset while a command is pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {cmd_valid, cmd_addr, cmd_len, fifo_flush, busy, late_frame},
              '0);

        // Zero geometry never issues.
        do_reset();
        vactive = 16'd0;
        hactive = 16'd100;
        cmd_ready = 1'b1;
        pulse_falign(32'hB000);
        repeat (10) tick();
        check("zero_vactive", {cmd_valid, busy}, 64'd0);

        // Mid-frame falign with 100 beats outstanding.
        do_reset();
        b1 = 32'h2000;
        b2 = 32'h8000;
        b3 = 32'hC000;
        st = 32'h400;
        vactive = 16'd2;
        hactive = 16'd100;
        line_stride = st;
        cmd_ready = 1'b1;
        push(b1, 9'd100);
        pulse_falign(b1);
        tick();
        tick();
        cmd_ready = 1'b0;
        tick();
        check("second_pending", {cmd_valid, cmd_addr}, {1'b1, b1 + st});
        pulse_falign(b2);
        check("late_set", {late_frame, cmd_valid, busy}, 64'b101);
        cmd_ready = 1'b1;
        push(b2, 9'd100);
        push(b2 + st, 9'd100);
        base0 = n_cmds;
        quiet = 1'b1;
        rd_beat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmd_valid || fifo_flush) quiet = 1'b0;
        end
        rd_beat = 1'b0;
        check("drain_quiet", 64'(quiet), 64'd1);
        tick();
        check("abort_flush", 64'(fifo_flush), 64'd1);
        tick();
        check("restart_valid", {cmd_valid, cmd_addr}, {1'b1, b2});
        wait_cmds(base0 + 2, "restart_cmds");
        tick();
        check("late_sticky", {late_frame, busy}, 64'b10);
        push(b3, 9'd100);
        push(b3 + st, 9'd100);
        base0 = n_cmds;
        pulse_falign(b3);
        check("late_cleared", 64'(late_frame), 64'd0);
        wait_cmds(base0 + 2, "clean_cmds");
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
